fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage feeding the cpu core; sits between the instruction memory port and decode/execute.
- Keeps a fetch PC and issues word reads over a req/ack memory handshake.
- Buffers fetched words with their PCs in a small prefetch FIFO and presents them to the core over a valid/ready interface.
- Flushes and redirects on branch or PC write-back from the core.

Parameters:
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- DEPTH, 4, prefetch FIFO entries; power of 2, at least 2.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- mem_req  output  1  read request to instruction memory
- mem_addr  output  32  word-aligned read address
- mem_ack  input  1  memory completes the read; mem_rdata is valid in the same cycle
- mem_rdata  input  32  read data
- branch_valid  input  1  redirect request from the core (one-cycle pulse)
- branch_target  input  32  redirect address; bits [1:0] ignored and forced to 0
- instr_valid  output  1  FIFO head holds a valid instruction
- instr  output  32  instruction word at FIFO head
- instr_pc  output  32  address of instr
- instr_ready  input  1  core accepts the head entry

Behaviour:
- Reset (reset=0, asynchronous):
  - mem_req=0, mem_addr=RESET_VECTOR, fetch PC=RESET_VECTOR.
  - FIFO empty, so instr_valid=0; instr=0 and instr_pc=0 (storage reset to 0).
  - State=IDLE.
- FSM states:
  - IDLE: no request outstanding. Go to REQ when the FIFO has space (count < DEPTH) and branch_valid=0. Otherwise stay.
  - REQ: mem_req=1; mem_addr and mem_req held stable until mem_ack.
    - On mem_ack: push {mem_rdata, fetch PC}, fetch PC += 4, go to IDLE.
    - If branch_valid=1 before or in the ack cycle: go to DISCARD; if the ack has already arrived, handle it as a DISCARD completion.
  - DISCARD: request still outstanding but stale; mem_req/mem_addr held.
    - On mem_ack: data dropped, no push, go to IDLE.
    - A further branch_valid here only updates fetch PC.
- Space check: the FIFO must never overflow. The transition to REQ requires count + (pending pop this cycle ? 0 : 0) < DEPTH, i.e. the conservative count < DEPTH. A pop in the same cycle does not grant space early.
- One outstanding request at most. IDLE->REQ costs one cycle, so back-to-back fetches issue every 2 cycles with a 1-cycle-ack memory.
- Consumer side:
  - instr_valid = (count != 0); instr/instr_pc come directly from registered FIFO head storage.
  - Pop when instr_valid & instr_ready.
  - Push and pop in the same cycle leave count unchanged.
  - FIFO pointers wrap modulo DEPTH.
- Branch (branch_valid=1 in cycle N):
  - FIFO cleared at the edge ending N; instr_valid=0 from N+1.
  - A pop handshake in cycle N still counts as consumed.
  - fetch PC <= {branch_target[31:2],2'b00}.
  - Branch has priority over any push in the same cycle (push dropped).
  - If IDLE in N: mem_req with the target address asserts in N+1 at earliest.
- Arithmetic: fetch PC += 4 modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- Reset asserted mid-transaction: all state is cleared immediately. A mem_ack arriving after reset release while IDLE is ignored.
- mem_ack while mem_req=0 (IDLE) is ignored.

Test Plan:
- Reset release, RESET_VECTOR=0, memory acks 1 cycle after req and returns addr^32'hA5A5_0000 -> mem_addr sequence 0,4,8,12; instr/instr_pc pairs (A5A5_0000,0),(A5A5_0004,4)... in order; instr_valid=0 throughout reset.
- instr_ready=0 held, DEPTH=4 -> exactly 4 pushes, then mem_req stays 0. Raise instr_ready for 1 cycle -> one pop, then one new request at address 16.
- branch_valid with target 32'h0000_1003 while IDLE with 2 entries buffered -> instr_valid=0 the next cycle; next mem_addr=32'h0000_1000; first delivered instr_pc=32'h0000_1000.
- branch_valid in REQ with ack delayed 3 cycles -> mem_addr held stable until ack; acked data never appears on instr; following request uses the branch target.
- RESET_VECTOR=32'hFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- reset pulsed low while mem_req=1 -> mem_req=0 and instr_valid=0 immediately (asynchronous); fetching restarts at RESET_VECTOR.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage. Keeps a fetch PC, issues single
//            outstanding word reads over a req/ack memory handshake, buffers
//            returned words with their PCs in a small prefetch FIFO and hands
//            them to the core over valid/ready. A branch from the core flushes
//            the FIFO and redirects the fetch PC.
// Ports    : clk, reset (async, active-low)
//            mem_req/mem_addr  -> read request + word address (held until ack)
//            mem_ack/mem_rdata <- read completion + data (same cycle)
//            branch_valid/branch_target <- redirect pulse + target address
//            instr_valid/instr/instr_pc -> FIFO head entry
//            instr_ready <- core accepts head entry
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          DEPTH        = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int              c_PTR_W     = $clog2(DEPTH);
    localparam int              c_CNT_W     = $clog2(DEPTH) + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_REQ     = 2'd1;
    localparam logic [1:0] c_ST_DISCARD = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic               w_start;
    logic               w_push;
    logic               w_pop;
    logic [31:0]        w_branch_pc;
    logic               w_unused_tgt_lsbs;

    logic [31:0]        r_pc;
    logic [31:0]        r_addr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [31:0]        r_fifo_instr [DEPTH];
    logic [31:0]        r_fifo_pc    [DEPTH];

    assign w_branch_pc       = {branch_target[31:2], 2'b00};
    assign w_unused_tgt_lsbs = ^branch_target[1:0];

    assign mem_req     = (r_state == c_ST_REQ) || (r_state == c_ST_DISCARD);
    assign mem_addr    = r_addr;
    assign instr_valid = (r_count != '0);
    assign instr       = r_fifo_instr[r_rd_ptr];
    assign instr_pc    = r_fifo_pc[r_rd_ptr];
    assign w_pop       = instr_valid && instr_ready;

    // ------------------------------------------------------------------
    // Fetch FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Fetch FSM: next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_push       = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                // Space is judged on the current count only; a pop in this
                // same cycle does not open a slot until the next cycle.
                if (!branch_valid && (r_count < c_DEPTH_CNT)) begin
                    w_state_next = c_ST_REQ;
                    w_start      = 1'b1;
                end
            end
            c_ST_REQ: begin
                if (branch_valid) begin
                    // An ack in the branch cycle completes a stale read.
                    w_state_next = mem_ack ? c_ST_IDLE : c_ST_DISCARD;
                end else if (mem_ack) begin
                    w_push       = 1'b1;
                    w_state_next = c_ST_IDLE;
                end
            end
            c_ST_DISCARD: begin
                if (mem_ack) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Fetch PC and request address
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc   <= RESET_VECTOR;
            r_addr <= RESET_VECTOR;
        end else begin
            // The address is captured once per request so that a redirect
            // while a read is outstanding cannot disturb mem_addr.
            if (w_start) begin
                r_addr <= r_pc;
            end
            if (branch_valid) begin
                r_pc <= w_branch_pc;
            end else if (w_push) begin
                r_pc <= r_pc + 32'd4;
            end
        end
    end

    // ------------------------------------------------------------------
    // Prefetch FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_instr[i] <= '0;
                r_fifo_pc[i]    <= '0;
            end
        end else if (branch_valid) begin
            // Flush wins over any push in the same cycle; a pop handshake
            // in this cycle is simply absorbed by the flush.
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_instr[r_wr_ptr] <= mem_rdata;
                r_fifo_pc[r_wr_ptr]    <= r_pc;
                r_wr_ptr               <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit. A transaction-level model
//            (expected fetch PC plus a queue of expected {instr, pc} entries)
//            is compared against the DUT every cycle; directed scenarios add
//            hand-computed literal checks. A second instance with a high
//            reset vector checks fetch-address wrap-around.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam int          DEPTH   = 4;
    localparam logic [31:0] RV0     = 32'h0000_0000;
    localparam logic [31:0] RV_WRAP = 32'hFFFF_FFF8;
    localparam logic [31:0] XOR_PAT = 32'hA5A5_0000;

    typedef struct packed {
        logic [31:0] d;
        logic [31:0] pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata = 32'hDEAD_BEEF;
    logic        branch_valid = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;

    // second instance (wrap-around reset vector)
    logic        w2_req;
    logic [31:0] w2_addr;
    logic        w2_ack;
    logic [31:0] w2_rdata;
    logic        w2_bv = 1'b0;
    logic [31:0] w2_bt = 32'h0;
    logic        w2_valid;
    logic [31:0] w2_instr;
    logic [31:0] w2_pc;
    logic        w2_ready = 1'b1;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_push = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_VECTOR(RV0), .DEPTH(DEPTH)) u_dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .branch_valid(branch_valid), .branch_target(branch_target),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready)
    );

    fetch_unit #(.RESET_VECTOR(RV_WRAP), .DEPTH(DEPTH)) u_dut_wrap (
        .clk(clk), .reset(reset),
        .mem_req(w2_req), .mem_addr(w2_addr), .mem_ack(w2_ack), .mem_rdata(w2_rdata),
        .branch_valid(w2_bv), .branch_target(w2_bt),
        .instr_valid(w2_valid), .instr(w2_instr), .instr_pc(w2_pc), .instr_ready(w2_ready)
    );

    assign w2_ack   = w2_req;
    assign w2_rdata = w2_addr ^ XOR_PAT;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Memory responder: ack after the request has been up for lat cycles
    // (lat=1 means ack in the first request cycle). spur injects an ack
    // that does not belong to any request.
    // ------------------------------------------------------------------
    int   lat = 1;
    int   wait_cnt = 0;
    logic real_ack = 1'b0;
    logic spur = 1'b0;
    assign mem_ack = real_ack | spur;

    always @(negedge clk) begin
        if (reset && mem_req) begin
            wait_cnt++;
            real_ack  = (wait_cnt >= lat);
            mem_rdata = mem_addr ^ XOR_PAT;
        end else begin
            wait_cnt  = 0;
            real_ack  = 1'b0;
            mem_rdata = 32'hDEAD_BEEF;
        end
    end

    // ------------------------------------------------------------------
    // Reference model: expected fetch PC and expected FIFO contents
    // ------------------------------------------------------------------
    ent_t        q[$];
    logic [31:0] m_pc = RV0;
    logic        stale = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            m_pc  = RV0;
            stale = 1'b0;
        end else begin
            ent_t e;
            if (q.size() != 0 && instr_ready) begin
                void'(q.pop_front());
            end
            if (mem_req && mem_ack) begin
                if (!stale && !branch_valid) begin
                    chk("no_overflow", {31'b0, (q.size() < DEPTH)}, 32'd1);
                    e.d  = mem_rdata;
                    e.pc = m_pc;
                    q.push_back(e);
                    n_push++;
                    m_pc = m_pc + 32'd4;
                end
                stale = 1'b0;
            end else if (mem_req && branch_valid) begin
                stale = 1'b1;
            end
            if (branch_valid) begin
                q.delete();
                m_pc = {branch_target[31:2], 2'b00};
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle compare against the model
    // ------------------------------------------------------------------
    logic        prev_req = 1'b0;
    logic [31:0] held_addr = 32'h0;

    always @(negedge clk) begin
        if (!reset) begin
            chk("reset_mem_req", {31'b0, mem_req}, 32'd0);
            chk("reset_instr_valid", {31'b0, instr_valid}, 32'd0);
            prev_req = 1'b0;
        end else begin
            chk("instr_valid", {31'b0, instr_valid}, {31'b0, (q.size() != 0)});
            if (q.size() != 0) begin
                chk("instr", instr, q[0].d);
                chk("instr_pc", instr_pc, q[0].pc);
            end
            if (mem_req) begin
                if (!prev_req) begin
                    chk("req_addr", mem_addr, m_pc);
                    chk("req_space", {31'b0, (q.size() < DEPTH)}, 32'd1);
                    held_addr = mem_addr;
                end else begin
                    chk("addr_hold", mem_addr, held_addr);
                end
            end
            prev_req = mem_req;
        end
    end

    // ------------------------------------------------------------------
    // Wrap-around instance recorder
    // ------------------------------------------------------------------
    logic [31:0] a2 [4];
    logic [31:0] p2 [4];
    int          n2a = 0;
    int          n2p = 0;

    always @(posedge clk) begin
        if (reset) begin
            if (w2_req && w2_ack && n2a < 4) begin
                a2[n2a] = w2_addr;
                n2a++;
            end
            if (w2_valid && n2p < 4) begin
                p2[n2p] = w2_pc;
                n2p++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Bounded waits (an expired bound shows up as a failed comparison)
    // ------------------------------------------------------------------
    task automatic wait_req(input logic lvl, input string nm);
        int k = 0;
        while (mem_req !== lvl && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk(nm, {31'b0, mem_req}, {31'b0, lvl});
    endtask

    task automatic wait_valid(input string nm);
        int k = 0;
        while (instr_valid !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk(nm, {31'b0, instr_valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] exp_wrap [4];
        exp_wrap[0] = 32'hFFFF_FFF8;
        exp_wrap[1] = 32'hFFFF_FFFC;
        exp_wrap[2] = 32'h0000_0000;
        exp_wrap[3] = 32'h0000_0004;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0000_0000);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_wrap_addr", w2_addr, 32'hFFFF_FFF8);

        // Release with a stray ack while IDLE; fill the FIFO with ready low
        @(negedge clk);
        n_push = 0;
        reset = 1'b1;
        spur  = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        repeat (12) @(negedge clk);
        chk("fill_push_count", n_push, 32'd4);
        chk("fill_head_instr", instr, 32'hA5A5_0000);
        chk("fill_head_pc", instr_pc, 32'h0000_0000);
        for (int i = 0; i < 3; i++) begin
            chk("full_no_req", {31'b0, mem_req}, 32'd0);
            @(negedge clk);
        end

        // Single pop: no early grant, then one request at 16
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        chk("pop_no_early_req", {31'b0, mem_req}, 32'd0);
        chk("pop_next_instr", instr, 32'hA5A5_0004);
        chk("pop_next_pc", instr_pc, 32'h0000_0004);
        @(negedge clk);
        chk("refill_req", {31'b0, mem_req}, 32'd1);
        chk("refill_addr", mem_addr, 32'h0000_0010);
        wait_req(1'b0, "refill_done");
        repeat (3) begin
            @(negedge clk);
            chk("refull_no_req", {31'b0, mem_req}, 32'd0);
        end

        // Asynchronous reset while a request is outstanding
        instr_ready = 1'b1;
        wait_req(1'b1, "pre_reset_req");
        #2;
        reset = 1'b0;
        #1;
        chk("async_mem_req", {31'b0, mem_req}, 32'd0);
        chk("async_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("async_mem_addr", mem_addr, 32'h0000_0000);
        @(negedge clk);
        instr_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        wait_req(1'b1, "restart_req");
        chk("restart_addr", mem_addr, 32'h0000_0000);

        // Branch while IDLE with two entries buffered
        begin
            int k = 0;
            while (!(q.size() == 2 && mem_req == 1'b0) && k < 40) begin
                @(negedge clk);
                k++;
            end
        end
        chk("two_buffered", q.size(), 32'd2);
        branch_valid  = 1'b1;
        branch_target = 32'h0000_1003;
        @(negedge clk);
        branch_valid = 1'b0;
        chk("br_flush_valid", {31'b0, instr_valid}, 32'd0);
        chk("br_idle_no_req", {31'b0, mem_req}, 32'd0);
        wait_req(1'b1, "br_req");
        chk("br_addr", mem_addr, 32'h0000_1000);
        wait_valid("br_valid");
        chk("br_instr_pc", instr_pc, 32'h0000_1000);
        chk("br_instr", instr, 32'hA5A5_1000);

        // Branch in REQ with ack arriving three cycles after the request
        instr_ready = 1'b1;
        wait_req(1'b0, "slow_idle");
        lat = 4;
        wait_req(1'b1, "slow_req");
        @(negedge clk);
        branch_valid  = 1'b1;
        branch_target = 32'h0000_2000;
        @(negedge clk);
        branch_valid = 1'b0;
        chk("slow_still_req", {31'b0, mem_req}, 32'd1);
        wait_req(1'b0, "slow_ack");
        chk("slow_stale_dropped", {31'b0, instr_valid}, 32'd0);
        wait_req(1'b1, "slow_next_req");
        chk("slow_next_addr", mem_addr, 32'h0000_2000);
        wait_valid("slow_valid");
        chk("slow_instr_pc", instr_pc, 32'h0000_2000);
        chk("slow_instr", instr, 32'hA5A5_2000);

        // Branch in the same cycle as the ack
        wait_req(1'b0, "same_idle");
        lat = 1;
        wait_req(1'b1, "same_req");
        branch_valid  = 1'b1;
        branch_target = 32'h0000_3002;
        @(negedge clk);
        branch_valid = 1'b0;
        chk("same_flush_valid", {31'b0, instr_valid}, 32'd0);
        wait_req(1'b1, "same_next_req");
        chk("same_next_addr", mem_addr, 32'h0000_3000);
        wait_valid("same_valid");
        chk("same_instr_pc", instr_pc, 32'h0000_3000);
        repeat (10) @(negedge clk);

        // Wrap-around instance: first four fetch addresses and delivered PCs
        chk("wrap_count", n2a, 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("wrap_addr", a2[i], exp_wrap[i]);
            chk("wrap_pc", p2[i], exp_wrap[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
